mdu: RTL and testbench
======================

MDU -- requirements
Module: mdu

Interface
REQ-001 The block SHALL take parameter WIDTH, default 32, as the operand and HI/LO register width.
REQ-002 The block SHALL take parameter MUL_LAT, default 5, as the busy cycles for MULT/MULTU; legal range is 1 to 255.
REQ-003 The block SHALL take parameter DIV_LAT, default 10, as the busy cycles for DIV/DIVU; legal range is 1 to 255.
REQ-004 Port clk, input, 1 bit: single clock; all state SHALL update on the rising edge.
REQ-005 Port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port start, input, 1 bit: request to issue op this cycle.
REQ-007 Port op, input, 3 bits: operation code, defined in mdu_pkg (MULT, MULTU, DIV, DIVU, MTHI, MTLO).
REQ-008 Port a, input, WIDTH bits: rs operand.
REQ-009 Port b, input, WIDTH bits: rt operand.
REQ-010 Port cancel, input, 1 bit: abort any in-flight operation.
REQ-011 Port busy, output, 1 bit: an operation is in flight.
REQ-012 Port hi, output, WIDTH bits: architectural HI.
REQ-013 Port lo, output, WIDTH bits: architectural LO.

Function
REQ-014 An issue SHALL be accepted only when start=1, busy=0 and cancel=0; start under any other condition SHALL be ignored, with no state change.
REQ-015 An accepted MULT/MULTU/DIV/DIVU SHALL latch a and b in the issue cycle; later changes on a or b SHALL have no effect.
REQ-016 After an accepted MULT/MULTU/DIV/DIVU issued in cycle t, busy SHALL be 1 in cycles t+1 through t+LAT, where LAT is MUL_LAT or DIV_LAT.
REQ-017 For the same issue, hi and lo SHALL take the new values in cycle t+LAT+1, the same cycle busy returns to 0.
REQ-018 A new issue SHALL be accepted in cycle t+LAT+1.
REQ-019 MULT SHALL produce the signed 2*WIDTH-bit product of a and b; MULTU SHALL produce the unsigned product; the upper half SHALL go to hi and the lower half to lo.
REQ-020 DIV SHALL produce lo = signed quotient truncated toward zero and hi = remainder carrying the sign of the dividend; DIVU SHALL produce the unsigned quotient and remainder.
REQ-021 For DIV/DIVU with b=0, hi and lo SHALL remain unchanged after the busy period, and the busy period SHALL still run DIV_LAT cycles.
REQ-022 For DIV with a = most-negative value and b = -1, the result SHALL be lo = most-negative value and hi = 0.
REQ-023 MTHI/MTLO SHALL write a into hi or lo respectively at the issue edge, visible in cycle t+1, and SHALL NOT assert busy.
REQ-024 cancel=1 while busy=1 SHALL drop busy in the next cycle and discard the pending result, leaving hi and lo unchanged.
REQ-025 cancel=1 in the final busy cycle SHALL still discard the pending result.
REQ-026 cancel=1 while idle SHALL have no effect, and any concurrent start SHALL be ignored.
REQ-027 The busy down-counter SHALL be 8 bits wide and SHALL NOT wrap; it SHALL stop at zero.
REQ-028 An op code outside the defined set SHALL be ignored and treated as no issue.

Reset
REQ-029 Assertion of reset (reset=0) SHALL immediately clear busy, hi, lo, the counter and the pending result to 0, without waiting for clk.
REQ-030 Reset asserted mid-operation SHALL abort the operation; after deassertion the block SHALL be idle, with no late write to hi/lo.
REQ-031 Deassertion of reset SHALL be treated as synchronous to clk, and the first issue SHALL be accepted on the first rising edge after deassertion.

Structure
REQ-032 The op-code localparams and the latency defaults SHALL live in the shared package mdu_pkg; the pipeline CU and stall logic SHALL import the same codes.
REQ-033 The block SHALL be two parts: a control part (IDLE/BUSY states and the counter) and a datapath (operand latch, result compute, pending HI/LO registers).
REQ-034 No separate sub-module is required; an optional sub-module mdu_ctrl MAY hold the IDLE/BUSY counter logic.
REQ-035 Results MAY be computed combinationally from the latched operands, provided the REQ-016/REQ-017 commit timing is exact.

Verification
REQ-036 The bench SHALL drive MULT with a=0xFFFFFFFE (-2), b=3 and check: busy high for exactly 5 cycles, then hi=0xFFFFFFFF and lo=0xFFFFFFFA.
REQ-037 The bench SHALL drive DIV with a=-7, b=2 and check: after 10 busy cycles lo=0xFFFFFFFD (-3) and hi=0xFFFFFFFF (-1); DIVU with a=7, b=2 SHALL give lo=3, hi=1.
REQ-038 The bench SHALL do MTHI a=0x1234, then DIV by b=0, and check: hi=0x1234 and lo is unchanged after 10 busy cycles.
REQ-039 The bench SHALL issue MULTU a=0xFFFFFFFF, b=0xFFFFFFFF, then pulse start with MTLO during busy, and check: MTLO is ignored, and finally hi=0xFFFFFFFE, lo=0x00000001.
REQ-040 The bench SHALL start DIV, assert cancel in busy cycle 4, and check: busy is 0 in the next cycle and hi/lo are unchanged; it SHALL repeat with reset=0 asserted mid-operation and check all outputs are 0 with no later write.
REQ-041 The bench SHALL rerun with parameters WIDTH=16, MUL_LAT=1, DIV_LAT=1, issue MULT with a=0x8000, b=0x8000, and check: busy lasts 1 cycle, then hi=0x4000, lo=0x0000.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared op codes, latency defaults and state type for the multiply/divide unit.
// The pipeline control unit and stall logic import the same op codes.
package mdu_pkg;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    localparam int MUL_LAT_DEF = 5;
    localparam int DIV_LAT_DEF = 10;
    localparam int CNT_W       = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mdu_state_t;

    function automatic logic is_long_op(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic is_div_op(input logic [2:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic is_signed_op(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/mdu_ctrl.sv
// IDLE/BUSY sequencer for the MDU: loads the latency into a saturating
// down-counter on issue and flags the commit edge when it reaches one.
//
//   state   | meaning
//   --------+-----------------------------------------------
//   ST_IDLE | no operation in flight, new issues accepted
//   ST_BUSY | long op in flight, cnt = busy cycles remaining
module mdu_ctrl
    import mdu_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             issue,
    input  logic [CNT_W-1:0] lat,
    input  logic             cancel,
    output logic             busy,
    output logic             commit
);

    mdu_state_t       state;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (issue) begin
                        state <= ST_BUSY;
                        busy  <= 1'b1;
                        cnt   <= lat;
                    end
                end
                ST_BUSY: begin
                    if (cancel || (cnt <= CNT_W'(1))) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Commit happens on the edge closing the last busy cycle, unless cancelled in it.
    assign commit = (state == ST_BUSY) && !cancel && (cnt == CNT_W'(1));

endmodule

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Operands are latched at issue; results are computed from the latch and committed at the end of busy.
module mdu
    import mdu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int DIV_LAT = DIV_LAT_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT);
    localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT);

    logic             accept;
    logic             long_issue;
    logic             commit;
    logic [CNT_W-1:0] lat;

    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;

    logic [2*WIDTH-1:0] ext_a;
    logic [2*WIDTH-1:0] ext_b;
    logic [2*WIDTH-1:0] prod;
    logic               neg_a;
    logic               neg_b;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH-1:0]   div_b;
    logic [WIDTH-1:0]   q_mag;
    logic [WIDTH-1:0]   r_mag;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;
    logic               wr_ok;

    assign accept     = start && !busy && !cancel;
    assign long_issue = accept && is_long_op(op);
    assign lat        = is_div_op(op) ? DIV_CNT : MUL_CNT;

    mdu_ctrl u_ctrl (
        .clk    (clk),
        .reset  (reset),
        .issue  (long_issue),
        .lat    (lat),
        .cancel (cancel),
        .busy   (busy),
        .commit (commit)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q <= '0;
            a_q  <= '0;
            b_q  <= '0;
        end else if (long_issue) begin
            op_q <= op;
            a_q  <= a;
            b_q  <= b;
        end
    end

    // Sign/magnitude division keeps MIN/-1 well defined: |MIN| fits unsigned and negates back to MIN.
    always_comb begin
        ext_a  = is_signed_op(op_q) ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
        ext_b  = is_signed_op(op_q) ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
        prod   = ext_a * ext_b;
        neg_a  = is_signed_op(op_q) && a_q[WIDTH-1];
        neg_b  = is_signed_op(op_q) && b_q[WIDTH-1];
        mag_a  = neg_a ? (WIDTH'(0) - a_q) : a_q;
        mag_b  = neg_b ? (WIDTH'(0) - b_q) : b_q;
        div_b  = (b_q == '0) ? WIDTH'(1) : mag_b;
        q_mag  = mag_a / div_b;
        r_mag  = mag_a % div_b;
        res_hi = prod[2*WIDTH-1:WIDTH];
        res_lo = prod[WIDTH-1:0];
        wr_ok  = 1'b1;
        if (is_div_op(op_q)) begin
            res_lo = (neg_a ^ neg_b) ? (WIDTH'(0) - q_mag) : q_mag;
            res_hi = neg_a ? (WIDTH'(0) - r_mag) : r_mag;
            wr_ok  = (b_q != '0);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi <= '0;
            lo <= '0;
        end else if (commit) begin
            if (wr_ok) begin
                hi <= res_hi;
                lo <= res_lo;
            end
        end else if (accept && (op == OP_MTHI)) begin
            hi <= a;
        end else if (accept && (op == OP_MTLO)) begin
            lo <= a;
        end
    end

endmodule

// File: tb/tb_mdu.sv
// Directed self-checking bench for mdu: default 32-bit instance plus a
// 16-bit single-cycle-latency instance.
module tb_mdu;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        cancel = 1'b0;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    logic        s_start = 1'b0;
    logic [2:0]  s_op = 3'd0;
    logic [15:0] s_a = '0;
    logic [15:0] s_b = '0;
    logic        s_cancel = 1'b0;
    logic        s_busy;
    logic [15:0] s_hi;
    logic [15:0] s_lo;

    int total = 0;
    int bad = 0;
    int n;

    always #5 clk = ~clk;

    mdu dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .cancel(cancel), .busy(busy), .hi(hi), .lo(lo)
    );

    mdu #(.WIDTH(16), .MUL_LAT(1), .DIV_LAT(1)) dut_s (
        .clk(clk), .reset(reset), .start(s_start), .op(s_op), .a(s_a), .b(s_b),
        .cancel(s_cancel), .busy(s_busy), .hi(s_hi), .lo(s_lo)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        start = 1'b1;
        op = o;
        a = x;
        b = y;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = 32'hA5A5_5A5A;
        b = 32'h0000_0003;
    endtask

    task automatic wait_idle(output int cnt);
        cnt = 0;
        @(negedge clk);
        while (busy && cnt < 300) begin
            cnt++;
            @(negedge clk);
        end
    endtask

    initial begin
        #2 reset = 1'b0;
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        chk("rst_s_hi", 64'(s_hi), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        issue(OP_MULT, 32'hFFFF_FFFE, 32'd3);
        wait_idle(n);
        chk("mult_busy_cycles", 64'(n), 64'd5);
        chk("mult_hi", 64'(hi), 64'hFFFF_FFFF);
        chk("mult_lo", 64'(lo), 64'hFFFF_FFFA);

        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_idle(n);
        chk("div_busy_cycles", 64'(n), 64'd10);
        chk("div_hi", 64'(hi), 64'hFFFF_FFFF);
        chk("div_lo", 64'(lo), 64'hFFFF_FFFD);

        issue(OP_DIVU, 32'd7, 32'd2);
        wait_idle(n);
        chk("divu_hi", 64'(hi), 64'd1);
        chk("divu_lo", 64'(lo), 64'd3);

        issue(OP_MTHI, 32'h1234, 32'd0);
        @(negedge clk);
        chk("mthi_busy", 64'(busy), 64'd0);
        chk("mthi_hi", 64'(hi), 64'h1234);

        issue(OP_DIV, 32'd5, 32'd0);
        wait_idle(n);
        chk("div0_busy_cycles", 64'(n), 64'd10);
        chk("div0_hi", 64'(hi), 64'h1234);
        chk("div0_lo", 64'(lo), 64'd3);

        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle(n);
        chk("divmin_hi", 64'(hi), 64'd0);
        chk("divmin_lo", 64'(lo), 64'h8000_0000);

        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        @(negedge clk);
        start = 1'b1;
        op = OP_MTLO;
        a = 32'hDEAD;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_idle(n);
        chk("multu_rest_cycles", 64'(n), 64'd4);
        chk("multu_hi", 64'(hi), 64'hFFFF_FFFE);
        chk("multu_lo", 64'(lo), 64'd1);

        issue(OP_DIV, 32'd100, 32'd7);
        repeat (3) @(negedge clk);
        @(negedge clk);
        cancel = 1'b1;
        @(posedge clk);
        #1;
        cancel = 1'b0;
        @(negedge clk);
        chk("cancel4_busy", 64'(busy), 64'd0);
        repeat (12) @(negedge clk);
        chk("cancel4_hi", 64'(hi), 64'hFFFF_FFFE);
        chk("cancel4_lo", 64'(lo), 64'd1);

        issue(OP_DIV, 32'd100, 32'd7);
        repeat (9) @(negedge clk);
        @(negedge clk);
        cancel = 1'b1;
        @(posedge clk);
        #1;
        cancel = 1'b0;
        @(negedge clk);
        chk("cancel_last_busy", 64'(busy), 64'd0);
        chk("cancel_last_hi", 64'(hi), 64'hFFFF_FFFE);
        chk("cancel_last_lo", 64'(lo), 64'd1);

        @(negedge clk);
        start = 1'b1;
        cancel = 1'b1;
        op = OP_MTHI;
        a = 32'h55;
        @(posedge clk);
        #1;
        start = 1'b0;
        cancel = 1'b0;
        @(negedge clk);
        chk("idle_cancel_hi", 64'(hi), 64'hFFFF_FFFE);
        chk("idle_cancel_busy", 64'(busy), 64'd0);

        issue(3'd6, 32'h99, 32'h2);
        @(negedge clk);
        chk("badop_busy", 64'(busy), 64'd0);
        chk("badop_hi", 64'(hi), 64'hFFFF_FFFE);
        chk("badop_lo", 64'(lo), 64'd1);

        issue(OP_MULT, 32'd3, 32'd4);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_hi", 64'(hi), 64'd0);
        chk("midrst_lo", 64'(lo), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        op = OP_MTLO;
        a = 32'h77;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (8) @(negedge clk);
        chk("postrst_busy", 64'(busy), 64'd0);
        chk("postrst_hi", 64'(hi), 64'd0);
        chk("postrst_lo", 64'(lo), 64'h77);

        @(negedge clk);
        s_start = 1'b1;
        s_op = OP_MULT;
        s_a = 16'h8000;
        s_b = 16'h8000;
        @(posedge clk);
        #1;
        s_start = 1'b0;
        s_a = 16'h1111;
        n = 0;
        @(negedge clk);
        while (s_busy && n < 300) begin
            n++;
            @(negedge clk);
        end
        chk("small_busy_cycles", 64'(n), 64'd1);
        chk("small_hi", 64'(s_hi), 64'h4000);
        chk("small_lo", 64'(s_lo), 64'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
